cpu_player: RTL and testbench

CPU_PLAYER -- requirements
Module: cpu_player

---
 rtl/cpu_player.sv | 127 ++++++++++++
 tb/tb_cpu_player.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_player.sv
// cpu_player: LFSR-paced CPU opponent that issues single-cycle key presses.
// Optional press statistics counter enabled by defining CPU_PLAYER_STATS_EN.
module cpu_player #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned COOLDOWN = 2,
    parameter logic [9:0]  SEED     = 10'h001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       game_over,
    input  logic [8:0] difficulty,
    output logic       press,
    output logic [7:0] press_count
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int HW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRE,
        HOLD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] div_q;
    logic [9:0]    lfsr_q;
    logic [HW-1:0] hold_q;
    logic          tick;
    logic          halt;
    logic          shoot;
    logic          press_d;

    assign tick  = (div_q == DIV_LAST);
    assign halt  = !enable || game_over;
    assign shoot = tick && (lfsr_q[8:0] < difficulty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + CW'(1);
        end
    end

    // x^10 + x^7 + 1; an all-zero register would lock up, so reseed it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (tick) begin
            if (lfsr_q == 10'd0) begin
                lfsr_q <= SEED;
            end else begin
                lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (state_q == FIRE) begin
            hold_q <= '0;
        end else if (state_q == HOLD && tick) begin
            hold_q <= hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (halt) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  state_d = ARMED;
                ARMED: if (shoot) state_d = FIRE;
                FIRE:  state_d = HOLD;
                HOLD:  if (tick && hold_q == HOLD_LAST) state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        press_d = (state_d == FIRE);
    end

    // registered so press mirrors the FIRE state without combinational glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press <= 1'b0;
        end else begin
            press <= press_d;
        end
    end

`ifdef CPU_PLAYER_STATS_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else if (state_q == FIRE && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign press_count = count_q;
`else
    assign press_count = 8'd0;
`endif

endmodule

// File: tb/tb_cpu_player.sv
// tb_cpu_player: directed, table-driven bench for cpu_player.
// Uses TICK_DIV=4, COOLDOWN=2, SEED=10'h001.
module tb_cpu_player;

    localparam logic [9:0] SEED = 10'h001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       game_over = 1'b0;
    logic [8:0] difficulty = 9'd0;
    logic       press;
    logic [7:0] press_count;

    int checks = 0;
    int failures = 0;

    logic got [1:5000];
    int   pe [4];
    int   np_last;

    typedef struct {
        logic [8:0] d;
        int         e0;
        int         e1;
        int         e2;
        int         e3;
    } vec_t;

    vec_t vecs [6];

    cpu_player #(
        .TICK_DIV(4),
        .COOLDOWN(2),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .game_over(game_over),
        .difficulty(difficulty),
        .press(press),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        if (v == 10'd0) return SEED;
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [8:0] d);
        enable = 1'b1;
        game_over = 1'b0;
        difficulty = d;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_press", press, 0);
        check("rst_count", press_count, 0);
        reset = 1'b1;
    endtask

    task automatic capture(input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            got[e] = press;
        end
    endtask

    task automatic scan(input int n);
        int idx = 0;
        for (int i = 0; i < 4; i++) pe[i] = 0;
        for (int e = 1; e <= n; e++) begin
            if (got[e] === 1'b1 && idx < 4) begin
                pe[idx] = e;
                idx++;
            end
        end
    endtask

    // Predicts press edges from the LFSR sequence: tick k is evaluated at
    // edge 4(k+1); after a press at tick k the next ARMED evaluation is k+3.
    task automatic model_check(input logic [8:0] d, input int n,
                               input string name);
        logic [9:0] m;
        logic       exp_p;
        int         elig;
        int         mism;
        int         np_got;
        int         np_exp;
        int         k;
        start(d);
        capture(n);
        m = SEED;
        elig = 0;
        mism = 0;
        np_got = 0;
        np_exp = 0;
        for (int e = 1; e <= n; e++) begin
            exp_p = 1'b0;
            if (e % 4 == 0) begin
                k = e / 4 - 1;
                if (k >= elig && m[8:0] < d) begin
                    exp_p = 1'b1;
                    elig = k + 3;
                end
                m = lfsr_step(m);
            end
            if (got[e] !== exp_p) mism++;
            if (exp_p) np_exp++;
            if (got[e] === 1'b1) np_got++;
        end
        check({name, "_trace_mismatches"}, mism, 0);
        check({name, "_press_total"}, np_got, np_exp);
        np_last = np_exp;
    endtask

    initial begin
        int last;
        int min_gap;
        int adj;
        int exp_idx;
        int first;
        logic [9:0] m;

        vecs[0] = '{9'd511, 4, 16, 28, 40};
        vecs[1] = '{9'd100, 4, 16, 28, 40};
        vecs[2] = '{9'd60,  4, 16, 40, 52};
        vecs[3] = '{9'd36,  4, 16, 40, 80};
        vecs[4] = '{9'd32,  4, 16, 40, 96};
        vecs[5] = '{9'd13,  4, 16, 40, 96};

        for (int r = 0; r < 6; r++) begin
            start(vecs[r].d);
            capture(100);
            scan(100);
            check($sformatf("vec%0d_p0", r), pe[0], vecs[r].e0);
            check($sformatf("vec%0d_p1", r), pe[1], vecs[r].e1);
            check($sformatf("vec%0d_p2", r), pe[2], vecs[r].e2);
            check($sformatf("vec%0d_p3", r), pe[3], vecs[r].e3);
        end

        // difficulty 0 never presses; raising it is picked up at the next tick
        start(9'd0);
        capture(5000);
        first = 0;
        for (int e = 1; e <= 5000; e++) if (got[e] === 1'b1) first++;
        check("d0_press_total", first, 0);
        @(negedge clk);
        difficulty = 9'd511;
        capture(12);
        m = SEED;
        for (int i = 0; i < 1250; i++) m = lfsr_step(m);
        exp_idx = (m[8:0] < 9'd511) ? 4 : 8;
        scan(12);
        check("d0_to_511_first", pe[0], exp_idx);

        // max difficulty over a full LFSR period, with spacing checks
        model_check(9'd511, 4400, "d511");
        last = 0;
        min_gap = 100000;
        adj = 0;
        for (int e = 1; e <= 4400; e++) begin
            if (got[e] === 1'b1) begin
                if (last != 0 && e - last < min_gap) min_gap = e - last;
                if (e > 1 && got[e-1] === 1'b1) adj++;
                last = e;
            end
        end
        check("d511_min_gap", min_gap, 12);
        check("d511_wide_pulses", adj, 0);
`ifdef CPU_PLAYER_STATS_EN
        check("stats_count", press_count, (np_last > 255) ? 255 : np_last);
`else
        check("stats_count", press_count, 0);
`endif

        model_check(9'd256, 4400, "d256");

        // game_over on the cycle a tick would fire
        start(9'd511);
        capture(3);
        @(negedge clk);
        game_over = 1'b1;
        @(posedge clk);
        #1;
        check("go_press_e4", press, 0);
        @(negedge clk);
        game_over = 1'b0;
        for (int e = 5; e <= 7; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("go_press_e%0d", e), press, 0);
        end
        @(posedge clk);
        #1;
        check("go_resume_e8", press, 1);

        // asynchronous reset in the middle of a FIRE cycle
        start(9'd511);
        capture(4);
        check("mid_fire_press", got[4], 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_press_drop", press, 0);
        check("mid_rst_count", press_count, 0);
        @(negedge clk);
        check("mid_rst_hold_press", press, 0);
        reset = 1'b1;
        capture(40);
        scan(40);
        check("mid_rst_p0", pe[0], 4);
        check("mid_rst_p1", pe[1], 16);
        check("mid_rst_p3", pe[3], 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
